// File: rtl/tdc_uart_tx.sv
// ============================================================================
// Module   : tdc_uart_tx
// Brief    : TDC snapshot transmitter: 2-entry FIFO of tagged bytes, UART 8N1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_uart_tx #(
  parameter int num_stages   = 5,
  parameter int clks_per_bit = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [num_stages-1:0] stage_delays_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  tx,
  output logic                  busy,
  output logic [7:0]            frame_count
);

  localparam int c_baud_w = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(clks_per_bit - 1);
  localparam logic [2:0] c_tag = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                r_state;
  logic [7:0]            r_fifo [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [7:0]            r_shift;
  logic [2:0]            r_bit_idx;
  logic [c_baud_w-1:0]   r_baud;
  logic                  r_tx;
  logic [7:0]            r_frame_count;

  logic [4:0]            w_stage_ext;
  logic [7:0]            w_byte;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_nonempty;
  logic                  w_baud_done;

  always_comb begin
    w_stage_ext                 = '0;
    w_stage_ext[num_stages-1:0] = stage_delays_in;
  end

  assign w_byte      = {c_tag, w_stage_ext};
  assign w_nonempty  = (r_count != 2'd0);
  assign w_baud_done = (r_baud == c_baud_last);
  assign w_push      = sample_valid && sample_ready;
  // Pop either from idle or on the final stop-bit edge for back-to-back frames
  assign w_pop       = w_nonempty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));

  assign sample_ready = (r_count < 2'd2);
  assign busy         = (r_state != ST_IDLE) || w_nonempty;
  assign tx           = r_tx;
  assign frame_count  = r_frame_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= 8'd0;
      r_bit_idx     <= 3'd0;
      r_baud        <= '0;
      r_tx          <= 1'b1;
      r_frame_count <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_fifo[r_rd_ptr];
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
        end

        ST_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_baud_done) begin
            r_baud        <= '0;
            r_frame_count <= r_frame_count + 8'd1;
            if (w_pop) begin
              r_shift <= r_fifo[r_rd_ptr];
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdc_uart_tx.sv
// ============================================================================
// Module   : tb_tdc_uart_tx
// Brief    : Scoreboard bench for tdc_uart_tx (5-stage and 3-stage instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdc_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [4:0] data;
    logic       exp_ready;
    logic [7:0] exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d5;
  logic       v5;
  logic       rdy5, tx5, busy5;
  logic [7:0] fc5;
  logic [2:0] d3;
  logic       v3;
  logic       rdy3, tx3, busy3;
  logic [7:0] fc3;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         mon_skip = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_uart_tx #(.num_stages(5), .clks_per_bit(CPB)) u_dut5 (
    .clk(clk), .reset(reset), .stage_delays_in(d5), .sample_valid(v5),
    .sample_ready(rdy5), .tx(tx5), .busy(busy5), .frame_count(fc5)
  );

  tdc_uart_tx #(.num_stages(3), .clks_per_bit(CPB)) u_dut3 (
    .clk(clk), .reset(reset), .stage_delays_in(d3), .sample_valid(v3),
    .sample_ready(rdy3), .tx(tx3), .busy(busy3), .frame_count(fc3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle5(input int max);
    for (int k = 0; k < max && busy5 !== 1'b0; k++) @(negedge clk);
    check("idle_timeout", busy5, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    starts.delete();
  endtask

  // UART receiver on the 5-stage instance, sampling mid-bit
  initial begin
    logic [7:0] b;
    logic       st, sp;
    forever begin
      @(negedge clk);
      if (tx5 === 1'b0 && reset === 1'b0) begin
        starts.push_back(cyc);
        repeat (CPB/2) @(negedge clk);
        st = tx5;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx5;
        end
        repeat (CPB) @(negedge clk);
        sp = tx5;
        if (mon_skip) begin
          mon_skip = 1'b0;
        end else begin
          check("start_bit", st, 0);
          check("stop_bit", sp, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h, expected no frame", b);
          end else begin
            check("frame_byte", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       b2b [4];
    vec_t       sf  [4];
    logic [7:0] exp3;
    int         acc;

    b2b[0] = '{5'b00001, 1'b1, 8'hA1};
    b2b[1] = '{5'b11111, 1'b1, 8'hBF};
    b2b[2] = '{5'b00000, 1'b1, 8'hA0};
    b2b[3] = '{5'b11100, 1'b0, 8'hBC};
    sf[0]  = '{5'b01010, 1'b1, 8'hAA};
    sf[1]  = '{5'b11001, 1'b1, 8'hB9};
    sf[2]  = '{5'b00111, 1'b1, 8'hA7};
    sf[3]  = '{5'b10000, 1'b1, 8'hB0};

    reset = 1'b1; v5 = 1'b0; d5 = '0; v3 = 1'b0; d3 = '0;
    repeat (2) @(negedge clk);
    check("reset_tx", tx5, 1);
    check("reset_ready", rdy5, 1);
    check("reset_busy", busy5, 0);
    check("reset_fc", fc5, 0);
    reset = 1'b0;

    // Single frame: latency and frame timing
    @(negedge clk);
    d5 = 5'b10110; v5 = 1'b1; exp_q.push_back(8'hB6);
    @(negedge clk);
    v5 = 1'b0;
    check("latency_tx_high", tx5, 1);
    check("latency_busy", busy5, 1);
    @(negedge clk);
    check("tx_fall", tx5, 0);
    repeat (39) @(negedge clk);
    check("last_stop_fc", fc5, 0);
    check("last_stop_busy", busy5, 1);
    check("last_stop_tx", tx5, 1);
    @(negedge clk);
    check("frame_done_fc", fc5, 1);
    check("frame_done_busy", busy5, 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sf_ready", rdy5, 32'(sf[i].exp_ready));
      d5 = sf[i].data; v5 = 1'b1; exp_q.push_back(sf[i].exp_byte);
      @(negedge clk);
      v5 = 1'b0;
      wait_idle5(100);
      check("sf_fc", fc5, 32'(i + 2));
    end

    // Back-to-back with a push attempted while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d5 = b2b[i].data; v5 = 1'b1;
      check("b2b_ready", rdy5, 32'(b2b[i].exp_ready));
      if (b2b[i].exp_ready) exp_q.push_back(b2b[i].exp_byte);
    end
    @(negedge clk);
    v5 = 1'b0;
    wait_idle5(500);
    check("b2b_fc", fc5, 3);
    check("b2b_nframes", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], 10*CPB);
      check("b2b_gap2", starts[2] - starts[1], 10*CPB);
    end
    check("b2b_queue_empty", exp_q.size(), 0);

    // Backpressure: valid held high, data changing every cycle
    do_reset();
    acc = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      d5 = 5'($urandom); v5 = 1'b1;
      if (rdy5) begin
        exp_q.push_back({3'b101, d5});
        acc++;
      end
    end
    @(negedge clk);
    v5 = 1'b0;
    wait_idle5(500);
    check("bp_fc", fc5, 32'(acc % 256));
    check("bp_queue_empty", exp_q.size(), 0);

    // num_stages=3 instance, input changed right after the push
    @(negedge clk);
    d3 = 3'b101; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0; d3 = 3'b010;
    for (int k = 0; k < 10 && tx3 !== 1'b0; k++) @(negedge clk);
    check("ns3_tx_fall", tx3, 0);
    exp3 = 8'hA5;
    repeat (CPB/2) @(negedge clk);
    check("ns3_start", tx3, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      check("ns3_bit", tx3, 32'(exp3[i]));
    end
    repeat (CPB) @(negedge clk);
    check("ns3_stop", tx3, 1);
    repeat (CPB) @(negedge clk);
    check("ns3_fc", fc3, 1);
    check("ns3_busy", busy3, 0);

    // Reset during DATA bit 3 with one byte still queued
    do_reset();
    @(negedge clk);
    d5 = 5'b10011; v5 = 1'b1; exp_q.push_back(8'hB3);
    @(negedge clk);
    d5 = 5'b01100; exp_q.push_back(8'hAC);
    @(negedge clk);
    v5 = 1'b0;
    for (int k = 0; k < 10 && tx5 !== 1'b0; k++) @(negedge clk);
    check("rst_tx_fall", tx5, 0);
    repeat (18) @(negedge clk);
    check("rst_busy_before", busy5, 1);
    mon_skip = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_tx", tx5, 1);
    check("rst_busy", busy5, 0);
    check("rst_ready", rdy5, 1);
    check("rst_fc", fc5, 0);
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("rst_no_frame_busy", busy5, 0);
    check("rst_no_frame_tx", tx5, 1);
    @(negedge clk);
    d5 = 5'b00110; v5 = 1'b1; exp_q.push_back(8'hA6);
    @(negedge clk);
    v5 = 1'b0;
    wait_idle5(100);
    check("rst_after_fc", fc5, 1);
    check("rst_queue_empty", exp_q.size(), 0);

    // 256 frames in two bursts: frame_count wraps to 0
    do_reset();
    for (int burst = 0; burst < 2; burst++) begin
      acc = 0;
      for (int k = 0; k < 8000 && acc < 128; k++) begin
        @(negedge clk);
        d5 = 5'($urandom); v5 = 1'b1;
        if (rdy5) begin
          exp_q.push_back({3'b101, d5});
          acc++;
        end
      end
      @(negedge clk);
      v5 = 1'b0;
      wait_idle5(500);
      check("wrap_burst_fc", fc5, (burst == 0) ? 128 : 0);
      acc = 1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (tx5 !== 1'b1) acc = 0;
      end
      check("wrap_idle_high", acc, 1);
    end
    check("wrap_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
